pattern_scan_ctrl: RTL and testbench

- Sequences packet words through the 64-bit shift-then-compare pattern matcher.
- Holds the search pattern and feeds one word per accepted beat to the matcher.
- Aligns the delayed matcher hit with the word that produced it, then drains the pipeline at end of packet.
- Reports one result per packet and clears the matcher between packets so no match spans two packets.

---
 rtl/pattern_scan_ctrl.sv | 157 +++++++++++++++
 tb/tb_pattern_scan_ctrl.sv | 254 +++++++++++++++++++++++++
 2 files changed

// File: rtl/pattern_scan_ctrl.sv
// Sequencing controller for the shift-then-compare pattern matcher: feeds packet words, aligns delayed hits, reports one result per packet.
// Optional per-packet hit counter output res_hits_o is enabled by defining PATTERN_SCAN_HITCNT_EN.
//
// state  | meaning
// IDLE   | waiting for a sop beat; pattern writes accepted
// SCAN   | streaming packet words to the matcher
// DRAIN  | waiting MATCH_LAT cycles for hits of the last words
// REPORT | result held on res_* until consumer is ready
// CLEAR  | one-cycle matcher flush before the next packet
module pattern_scan_ctrl #(
  parameter int DATA_WIDTH = 64,
  parameter int MATCH_LAT  = 2,
  parameter int WCNT_W     = 12
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic [DATA_WIDTH-1:0] cfg_pattern_i,
  input  logic                  cfg_we_i,
  output logic                  cfg_busy_o,
  input  logic [DATA_WIDTH-1:0] in_data_i,
  input  logic                  in_valid_i,
  input  logic                  in_sop_i,
  input  logic                  in_eop_i,
  output logic                  in_ready_o,
  output logic [DATA_WIDTH-1:0] mat_data_o,
  output logic [DATA_WIDTH-1:0] mat_pattern_o,
  output logic                  mat_clear_o,
  input  logic                  mat_hit_i,
  output logic                  res_valid_o,
  input  logic                  res_ready_i,
  output logic                  res_match_o,
  output logic [WCNT_W-1:0]     res_first_o,
  output logic [WCNT_W-1:0]     res_words_o
`ifdef PATTERN_SCAN_HITCNT_EN
  ,
  output logic [15:0]           res_hits_o
`endif
);

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_SCAN   = 3'd1;
  localparam logic [2:0] S_DRAIN  = 3'd2;
  localparam logic [2:0] S_REPORT = 3'd3;
  localparam logic [2:0] S_CLEAR  = 3'd4;

  localparam logic [2:0] DRAIN_LOAD = 3'(MATCH_LAT - 1);

  logic [2:0]            state_q, state_d;
  logic [2:0]            drain_cnt_q;
  logic [DATA_WIDTH-1:0] pattern_q;
  logic [DATA_WIDTH-1:0] mat_data_q;
  logic [WCNT_W-1:0]     wcnt_q;
  logic                  res_match_q;
  logic [WCNT_W-1:0]     res_first_q;
  logic                  tag_vld_q [MATCH_LAT];
  logic [WCNT_W-1:0]     tag_idx_q [MATCH_LAT];

  logic                  beat;
  logic                  pkt_beat;
  logic                  tag_hit;
  logic [WCNT_W-1:0]     cur_idx;

  assign in_ready_o  = (state_q == S_IDLE) || (state_q == S_SCAN);
  assign beat        = in_valid_i & in_ready_o;
  // In IDLE only a sop beat starts a packet; stray words are dropped.
  assign pkt_beat    = beat & ((state_q == S_SCAN) | in_sop_i);
  assign cur_idx     = (state_q == S_IDLE) ? '0 : wcnt_q;
  assign tag_hit     = mat_hit_i & tag_vld_q[MATCH_LAT-1];

  assign cfg_busy_o    = (state_q != S_IDLE);
  assign res_valid_o   = (state_q == S_REPORT);
  assign mat_clear_o   = (state_q == S_CLEAR);
  assign mat_data_o    = mat_data_q;
  assign mat_pattern_o = pattern_q;
  assign res_match_o   = res_match_q;
  assign res_first_o   = res_first_q;
  assign res_words_o   = wcnt_q;

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:   if (pkt_beat) state_d = in_eop_i ? S_DRAIN : S_SCAN;
      S_SCAN:   if (beat && in_eop_i) state_d = S_DRAIN;
      S_DRAIN:  if (drain_cnt_q == 3'd0) state_d = S_REPORT;
      S_REPORT: if (res_ready_i) state_d = S_CLEAR;
      S_CLEAR:  state_d = S_IDLE;
      default:  state_d = S_IDLE;
    endcase
  end

`ifdef PATTERN_SCAN_HITCNT_EN
  logic [15:0] hit_cnt_q;
  assign res_hits_o = hit_cnt_q;

  always_ff @(posedge clock) begin
    if (reset || state_q == S_CLEAR) begin
      hit_cnt_q <= '0;
    end else if (tag_hit && hit_cnt_q != 16'hFFFF) begin
      hit_cnt_q <= hit_cnt_q + 16'd1;
    end
  end
`endif

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q     <= S_IDLE;
      drain_cnt_q <= '0;
      pattern_q   <= '0;
      mat_data_q  <= '0;
      wcnt_q      <= '0;
      res_match_q <= 1'b0;
      res_first_q <= '0;
      for (int i = 0; i < MATCH_LAT; i++) begin
        tag_vld_q[i] <= 1'b0;
        tag_idx_q[i] <= '0;
      end
    end else begin
      state_q <= state_d;

      if (state_q == S_IDLE && cfg_we_i) pattern_q <= cfg_pattern_i;

      mat_data_q   <= pkt_beat ? in_data_i : '0;
      // Tag pipe output lines up with mat_hit_i for the same word.
      tag_vld_q[0] <= pkt_beat;
      tag_idx_q[0] <= cur_idx;
      for (int i = 1; i < MATCH_LAT; i++) begin
        tag_vld_q[i] <= tag_vld_q[i-1];
        tag_idx_q[i] <= tag_idx_q[i-1];
      end

      if (state_q != S_DRAIN && state_d == S_DRAIN) begin
        drain_cnt_q <= DRAIN_LOAD;
      end else if (state_q == S_DRAIN && drain_cnt_q != 3'd0) begin
        drain_cnt_q <= drain_cnt_q - 3'd1;
      end

      if (state_q == S_CLEAR) begin
        wcnt_q      <= '0;
        res_match_q <= 1'b0;
        res_first_q <= '0;
      end else begin
        if (pkt_beat) begin
          if (state_q == S_IDLE) begin
            wcnt_q <= {{(WCNT_W-1){1'b0}}, 1'b1};
          end else if (wcnt_q != {WCNT_W{1'b1}}) begin
            wcnt_q <= wcnt_q + 1'b1;
          end
        end
        if (tag_hit && !res_match_q) begin
          res_match_q <= 1'b1;
          res_first_q <= tag_idx_q[MATCH_LAT-1];
        end
      end
    end
  end

endmodule

// File: tb/tb_pattern_scan_ctrl.sv
// Self-checking bench for pattern_scan_ctrl: scripted packets, bench-side delayed hit generator, result scoreboard.
module tb_pattern_scan_ctrl;

  localparam int DW = 64;
  localparam int L  = 2;
  localparam int WW = 12;

  logic          clock = 1'b0;
  logic          reset;
  logic [DW-1:0] cfg_pattern_i;
  logic          cfg_we_i;
  logic          cfg_busy_o;
  logic [DW-1:0] in_data_i;
  logic          in_valid_i;
  logic          in_sop_i;
  logic          in_eop_i;
  logic          in_ready_o;
  logic [DW-1:0] mat_data_o;
  logic [DW-1:0] mat_pattern_o;
  logic          mat_clear_o;
  logic          mat_hit_i;
  logic          res_valid_o;
  logic          res_ready_i;
  logic          res_match_o;
  logic [WW-1:0] res_first_o;
  logic [WW-1:0] res_words_o;
`ifdef PATTERN_SCAN_HITCNT_EN
  logic [15:0]   res_hits_o;
`endif

  pattern_scan_ctrl #(.DATA_WIDTH(DW), .MATCH_LAT(L), .WCNT_W(WW)) dut (
    .clock(clock), .reset(reset),
    .cfg_pattern_i(cfg_pattern_i), .cfg_we_i(cfg_we_i), .cfg_busy_o(cfg_busy_o),
    .in_data_i(in_data_i), .in_valid_i(in_valid_i), .in_sop_i(in_sop_i),
    .in_eop_i(in_eop_i), .in_ready_o(in_ready_o),
    .mat_data_o(mat_data_o), .mat_pattern_o(mat_pattern_o), .mat_clear_o(mat_clear_o),
    .mat_hit_i(mat_hit_i),
    .res_valid_o(res_valid_o), .res_ready_i(res_ready_i), .res_match_o(res_match_o),
    .res_first_o(res_first_o), .res_words_o(res_words_o)
`ifdef PATTERN_SCAN_HITCNT_EN
    , .res_hits_o(res_hits_o)
`endif
  );

  always #5 clock = ~clock;

  typedef struct {
    logic match;
    int   first;
    int   words;
    int   hits;
  } exp_t;

  exp_t          exp_q[$];
  int            n_tests = 0;
  int            n_fail  = 0;
  int            cyc     = 0;
  int            eop_edge = 0;
  logic [DW-1:0] cur_pat = '0;

  // Matcher stand-in: a hit flagged with a driven cycle appears on mat_hit_i L cycles later.
  logic          beat_hit;
  logic [7:0]    hsr = '0;
  always @(posedge clock) begin
    cyc <= cyc + 1;
    hsr <= {hsr[6:0], beat_hit};
  end
  assign mat_hit_i = hsr[L-1];

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic idle_inputs();
    in_valid_i = 1'b0; in_sop_i = 1'b0; in_eop_i = 1'b0; in_data_i = '0;
    beat_hit = 1'b0; cfg_we_i = 1'b0;
  endtask

  task automatic drive(input logic v, input logic s, input logic e, input logic [DW-1:0] d,
                       input logic h, input logic acc);
    in_valid_i = v; in_sop_i = s; in_eop_i = e; in_data_i = d; beat_hit = h;
    @(posedge clock);
    @(negedge clock);
    check_eq("mat_data", mat_data_o, acc ? d : '0);
  endtask

  task automatic load_pattern(input logic [DW-1:0] p);
    cfg_pattern_i = p; cfg_we_i = 1'b1;
    @(posedge clock);
    @(negedge clock);
    cfg_we_i = 1'b0;
    cur_pat = p;
    check_eq("pattern_load", mat_pattern_o, p);
  endtask

  task automatic send_packet(input int n, input logic [15:0] hit_mask, input logic [15:0] gap_mask,
                             input logic do_we, input logic [DW-1:0] new_pat);
    exp_t e;
    e.match = 1'b0; e.first = 0; e.words = n; e.hits = 0;
    for (int i = 0; i < n; i++) begin
      if (hit_mask[i]) begin
        if (!e.match) begin e.match = 1'b1; e.first = i; end
        e.hits++;
      end
    end
    exp_q.push_back(e);
    for (int i = 0; i < n; i++) begin
      if (i == 0 && do_we) begin cfg_pattern_i = new_pat; cfg_we_i = 1'b1; end
      drive(1'b1, i == 0, i == n-1, {32'hA5A5_0000, 32'(i)}, hit_mask[i], 1'b1);
      if (i == 0 && do_we) begin
        cfg_we_i = 1'b0;
        cur_pat = new_pat;
        check_eq("pattern_with_sop", mat_pattern_o, new_pat);
      end
      if (i == n-1) eop_edge = cyc;
      else if (gap_mask[i]) drive(1'b0, 1'b0, 1'b0, 64'hDEAD, 1'b1, 1'b0);
    end
    idle_inputs();
  endtask

  task automatic get_result(input int hold);
    exp_t e;
    int   waited = 0;
    check_eq("drain_ready", in_ready_o, 1'b0);
    while (!res_valid_o && waited < 20) begin
      @(negedge clock);
      waited++;
    end
    if (!res_valid_o) begin
      check_eq("res_timeout", 0, 1);
      return;
    end
    check_eq("latency", 64'(cyc - eop_edge), L);
    if (exp_q.size() == 0) begin
      check_eq("sb_empty", 1, 0);
      return;
    end
    e = exp_q.pop_front();
    check_eq("res_match", res_match_o, e.match);
    check_eq("res_first", res_first_o, e.first);
    check_eq("res_words", res_words_o, e.words);
`ifdef PATTERN_SCAN_HITCNT_EN
    check_eq("res_hits", res_hits_o, e.hits);
`endif
    check_eq("report_ready", in_ready_o, 1'b0);
    check_eq("report_busy", cfg_busy_o, 1'b1);
    if (hold > 0) begin
      in_valid_i = 1'b1; in_sop_i = 1'b1; in_data_i = 64'h5555;
      cfg_we_i = 1'b1; cfg_pattern_i = ~cur_pat;
    end
    for (int i = 0; i < hold; i++) begin
      @(negedge clock);
      check_eq("hold_valid", res_valid_o, 1'b1);
      check_eq("hold_match", res_match_o, e.match);
      check_eq("hold_first", res_first_o, e.first);
      check_eq("hold_words", res_words_o, e.words);
      check_eq("hold_ready", in_ready_o, 1'b0);
      check_eq("hold_busy", cfg_busy_o, 1'b1);
      check_eq("hold_pattern", mat_pattern_o, cur_pat);
      check_eq("hold_mat_data", mat_data_o, '0);
    end
    idle_inputs();
    res_ready_i = 1'b1;
    @(negedge clock);
    res_ready_i = 1'b0;
    check_eq("clear_pulse", mat_clear_o, 1'b1);
    check_eq("clear_ready", in_ready_o, 1'b0);
    check_eq("clear_valid", res_valid_o, 1'b0);
    @(negedge clock);
    check_eq("clear_done", mat_clear_o, 1'b0);
    check_eq("idle_busy", cfg_busy_o, 1'b0);
    check_eq("idle_ready", in_ready_o, 1'b1);
    check_eq("idle_words", res_words_o, '0);
    check_eq("idle_match", res_match_o, 1'b0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    reset = 1'b1; res_ready_i = 1'b0; cfg_pattern_i = '0;
    idle_inputs();
    repeat (2) @(posedge clock);
    @(negedge clock);
    reset = 1'b0;
    check_eq("rst_ready", in_ready_o, 1'b1);
    check_eq("rst_busy", cfg_busy_o, 1'b0);
    check_eq("rst_valid", res_valid_o, 1'b0);
    check_eq("rst_clear", mat_clear_o, 1'b0);
    check_eq("rst_pattern", mat_pattern_o, '0);
    check_eq("rst_mat_data", mat_data_o, '0);
    check_eq("rst_words", res_words_o, '0);

    // Pattern load, 4-word packet with hit on word 2
    load_pattern(64'h0011_2233_4455_6677);
    send_packet(4, 16'b0100, 16'b0, 1'b0, '0);
    get_result(0);

    // Single-word packet, no hit
    send_packet(1, 16'b0, 16'b0, 1'b0, '0);
    get_result(0);

    // Consumer stalls for 10 cycles
    send_packet(3, 16'b001, 16'b0, 1'b0, '0);
    get_result(10);

    // Stray hits in IDLE and on bubbles; real hits at words 1 and 3
    for (int i = 0; i < 3; i++) drive(1'b0, 1'b0, 1'b0, 64'h77, 1'b1, 1'b0);
    send_packet(5, 16'b01010, 16'b00101, 1'b0, '0);
    get_result(0);

    // Reset during SCAN at word 3 discards the packet
    drive(1'b1, 1'b1, 1'b0, 64'h100, 1'b0, 1'b1);
    drive(1'b1, 1'b0, 1'b0, 64'h101, 1'b1, 1'b1);
    drive(1'b1, 1'b0, 1'b0, 64'h102, 1'b0, 1'b1);
    reset = 1'b1;
    drive(1'b1, 1'b0, 1'b0, 64'h103, 1'b0, 1'b0);
    reset = 1'b0;
    idle_inputs();
    cur_pat = '0;
    check_eq("mid_rst_ready", in_ready_o, 1'b1);
    check_eq("mid_rst_valid", res_valid_o, 1'b0);
    check_eq("mid_rst_pattern", mat_pattern_o, '0);
    check_eq("mid_rst_busy", cfg_busy_o, 1'b0);
    check_eq("mid_rst_words", res_words_o, '0);
    repeat (4) begin
      @(negedge clock);
      check_eq("mid_rst_no_result", res_valid_o, 1'b0);
    end

    // Fresh packet, pattern written together with sop
    send_packet(3, 16'b001, 16'b0, 1'b1, 64'h00AB_CDEF_0123_4567);
    get_result(0);

    // Words without sop in IDLE are dropped
    drive(1'b1, 1'b0, 1'b0, 64'h900, 1'b1, 1'b0);
    drive(1'b1, 1'b0, 1'b1, 64'h901, 1'b1, 1'b0);
    check_eq("drop_busy", cfg_busy_o, 1'b0);
    send_packet(2, 16'b10, 16'b0, 1'b0, '0);
    get_result(0);

    check_eq("sb_drained", exp_q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
